// File: rtl/rolling_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rolling_display_ctrl
// Brief    : Multiplexed 7-segment driver with static, scroll and blink modes
// Revision : 1.0 - initial release
// ============================================================================
module rolling_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_DEPTH  = 16,
  parameter int SCAN_DIV   = 100000,
  parameter int STEP_DIV   = 25000000,
  parameter int AW         = $clog2(MSG_DEPTH),
  parameter int LW         = $clog2(MSG_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [4:0]            wr_code,
  input  logic                  load,
  input  logic [LW-1:0]         msg_len,
  input  logic [1:0]            mode,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  wrap_pulse
);

  localparam int c_DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for offset + digit index, which can reach 2*period-2
  localparam int c_OW  = $clog2(2 * (MSG_DEPTH + NUM_DIGITS));
  localparam int c_SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_STW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] c_MODE_STATIC = 2'b00;
  localparam logic [1:0] c_MODE_LEFT   = 2'b01;
  localparam logic [1:0] c_MODE_RIGHT  = 2'b10;
  localparam logic [1:0] c_MODE_BLINK  = 2'b11;

  logic [4:0]            mem_q [MSG_DEPTH];
  logic [LW-1:0]         len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [c_OW-1:0]       offset_q, offset_d;
  logic [c_DW-1:0]       idx_q, idx_d;
  logic [c_SCW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [c_STW-1:0]      step_cnt_q, step_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  wrap_q, wrap_d;

  logic [c_OW-1:0] len_ext, period, sum, pos;
  logic [4:0]      cur_code;
  logic [LW-1:0]   len_clamped;
  logic            scan_last, step_last;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'b1111111;
      5'd1:    decode = 7'b0001001;
      5'd2:    decode = 7'b0000110;
      5'd3:    decode = 7'b1000111;
      5'd4:    decode = 7'b1000000;
      5'd5:    decode = 7'b1111001;
      5'd6:    decode = 7'b0001000;
      5'd7:    decode = 7'b1111000;
      5'd8:    decode = 7'b0000000;
      5'd9:    decode = 7'b0010000;
      5'd10:   decode = 7'b0001000;
      5'd11:   decode = 7'b0000011;
      5'd12:   decode = 7'b0100111;
      5'd13:   decode = 7'b0100001;
      5'd14:   decode = 7'b0000110;
      5'd15:   decode = 7'b0001110;
      default: decode = 7'b0100011;
    endcase
  endfunction

  // Window position: message followed by NUM_DIGITS blank slots
  assign len_ext     = c_OW'(len_q);
  assign period      = len_ext + c_OW'(NUM_DIGITS);
  assign sum         = offset_q + c_OW'(idx_q);
  assign pos         = (sum >= period) ? (sum - period) : sum;
  assign cur_code    = (pos < len_ext) ? mem_q[pos[AW-1:0]] : 5'd0;
  assign len_clamped = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
  assign scan_last   = (scan_cnt_q == c_SCW'(SCAN_DIV - 1));
  assign step_last   = (step_cnt_q == c_STW'(STEP_DIV - 1));

  always_comb begin
    len_d      = len_q;
    mode_d     = mode_q;
    offset_d   = offset_q;
    idx_d      = idx_q;
    scan_cnt_d = scan_cnt_q + c_SCW'(1);
    step_cnt_d = step_cnt_q + c_STW'(1);
    blink_on_d = blink_on_q;
    wrap_d     = 1'b0;

    if (scan_last) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == c_DW'(NUM_DIGITS - 1)) ? '0 : idx_q + c_DW'(1);
    end

    if (step_last) begin
      step_cnt_d = '0;
      case (mode_q)
        c_MODE_LEFT: begin
          if (offset_q == period - c_OW'(1)) begin
            offset_d = '0;
            wrap_d   = 1'b1;
          end else begin
            offset_d = offset_q + c_OW'(1);
          end
        end
        c_MODE_RIGHT: begin
          if (offset_q == '0) begin
            offset_d = period - c_OW'(1);
            wrap_d   = 1'b1;
          end else begin
            offset_d = offset_q - c_OW'(1);
          end
        end
        c_MODE_BLINK:  blink_on_d = ~blink_on_q;
        c_MODE_STATIC: ;
        default: ;
      endcase
    end

    // A load restarts the display and overrides any same-cycle step
    if (load) begin
      len_d      = len_clamped;
      mode_d     = mode;
      offset_d   = '0;
      idx_d      = '0;
      scan_cnt_d = '0;
      step_cnt_d = '0;
      blink_on_d = 1'b1;
      wrap_d     = 1'b0;
    end

    if ((mode_q == c_MODE_BLINK) && !blink_on_q) begin
      an_d = '1;
    end else begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
    end
    seg_d = decode(cur_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      mode_q     <= c_MODE_STATIC;
      offset_q   <= '0;
      idx_q      <= '0;
      scan_cnt_q <= '0;
      step_cnt_q <= '0;
      blink_on_q <= 1'b1;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      wrap_q     <= 1'b0;
    end else begin
      len_q      <= len_d;
      mode_q     <= mode_d;
      offset_q   <= offset_d;
      idx_q      <= idx_d;
      scan_cnt_q <= scan_cnt_d;
      step_cnt_q <= step_cnt_d;
      blink_on_q <= blink_on_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      wrap_q     <= wrap_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign wrap_pulse = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_rolling_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rolling_display_ctrl
// Brief    : Directed self-checking bench for rolling_display_ctrl (4 digits)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rolling_display_ctrl;

  localparam logic [31:0] c_S_BLANK = 32'h7F;  // 1111111
  localparam logic [31:0] c_S_1     = 32'h09;  // 0001001
  localparam logic [31:0] c_S_2     = 32'h06;  // 0000110
  localparam logic [31:0] c_S_3     = 32'h47;  // 1000111
  localparam logic [31:0] c_S_9     = 32'h10;  // 0010000
  localparam logic [31:0] c_S_HI    = 32'h23;  // 0100011

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_code;
  logic       load;
  logic [3:0] msg_len;
  logic [1:0] mode;
  logic [3:0] an;
  logic [6:0] seg;
  logic       wrap_pulse;

  int n_total = 0;
  int n_bad   = 0;
  int wraps;
  int wrap_k;

  logic [31:0] exp_an  [8] = '{32'hE, 32'hE, 32'hD, 32'hD, 32'hB, 32'hB, 32'h7, 32'h7};
  logic [31:0] exp_seg [8] = '{32'h09, 32'h09, 32'h06, 32'h06, 32'h47, 32'h47, 32'h7F, 32'h7F};

  rolling_display_ctrl #(
    .NUM_DIGITS(4),
    .MSG_DEPTH (8),
    .SCAN_DIV  (2),
    .STEP_DIV  (16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_code   (wr_code),
    .load      (load),
    .msg_len   (msg_len),
    .mode      (mode),
    .an        (an),
    .seg       (seg),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] c);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_code = c;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] len, input logic [1:0] m);
    msg_len = len;
    mode    = m;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_code = '0;
    load    = 1'b0;
    msg_len = '0;
    mode    = 2'b00;

    // Reset state and blank scan after release
    #12;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), c_S_BLANK);
    chk("rst_wrap", 32'(wrap_pulse), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rel_an", 32'(an), 32'hF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rel_seg", 32'(seg), c_S_BLANK);
      chk("rel_wrap", 32'(wrap_pulse), 32'd0);
      if (k == 1) chk("rel_an_d0", 32'(an), 32'hE);
      if (k == 3) chk("rel_an_d1", 32'(an), 32'hD);
    end

    // Static message 1,2,3
    wr(3'd0, 5'd1);
    wr(3'd1, 5'd2);
    wr(3'd2, 5'd3);
    do_load(4'd3, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("static_an", 32'(an), exp_an[k-1]);
      chk("static_seg", 32'(seg), exp_seg[k-1]);
    end

    // Scroll-left: period 7, single wrap after the 7th step
    do_load(4'd3, 2'b01);
    wraps  = 0;
    wrap_k = 0;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (wrap_pulse) begin
        wraps++;
        wrap_k = k;
      end
      if (k == 17) begin
        chk("left_step1_an", 32'(an), 32'hE);
        chk("left_step1_seg", 32'(seg), c_S_2);
      end
      if (k == 113) begin
        chk("left_back_an", 32'(an), 32'hE);
        chk("left_back_seg", 32'(seg), c_S_1);
      end
    end
    chk("left_wrap_cnt", 32'(wraps), 32'd1);
    chk("left_wrap_at", 32'(wrap_k), 32'd112);

    // Scroll-right: first step wraps 0 -> 6
    do_load(4'd3, 2'b10);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) chk("right_wrap_pre", 32'(wrap_pulse), 32'd0);
      if (k == 16) chk("right_wrap", 32'(wrap_pulse), 32'd1);
      if (k == 17) begin
        chk("right_wrap_post", 32'(wrap_pulse), 32'd0);
        chk("right_d0_an", 32'(an), 32'hE);
        chk("right_d0_seg", 32'(seg), c_S_BLANK);
      end
      if (k == 19) begin
        chk("right_d1_an", 32'(an), 32'hD);
        chk("right_d1_seg", 32'(seg), c_S_1);
      end
    end

    // Blink: dark during the off phase, scanning again once it returns
    do_load(4'd3, 2'b11);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 10) begin
        chk("blink_on_an", 32'(an), 32'hE);
        chk("blink_on_seg", 32'(seg), c_S_1);
      end
      if (k == 20) chk("blink_off_an_a", 32'(an), 32'hF);
      if (k == 30) chk("blink_off_an_b", 32'(an), 32'hF);
      if (k == 40) chk("blink_back_an", 32'(an), 32'h7);
      if (k == 56) chk("blink_off2_an", 32'(an), 32'hF);
    end

    // Write code 20 while scrolling, then reset mid-step
    do_load(4'd3, 2'b01);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) begin
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_code = 5'd20;
      end
      if (k == 6) wr_en = 1'b0;
      if (k == 9) begin
        chk("wr_d0_an", 32'(an), 32'hE);
        chk("wr_d0_seg", 32'(seg), c_S_HI);
      end
      if (k == 17) chk("wr_step_seg", 32'(seg), c_S_2);
      if (k == 19) chk("wr_step_d1_seg", 32'(seg), c_S_3);
    end
    rst_n = 1'b0;
    #2;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), c_S_BLANK);
    chk("midrst_wrap", 32'(wrap_pulse), 32'd0);
    #4;
    rst_n = 1'b1;
    do_load(4'd3, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        chk("clr_d0_an", 32'(an), 32'hE);
        chk("clr_d0_seg", 32'(seg), c_S_BLANK);
      end
      if (k == 3) chk("clr_d1_seg", 32'(seg), c_S_BLANK);
      if (k == 5) chk("clr_d2_seg", 32'(seg), c_S_BLANK);
    end

    // Oversized length clamps to 8: period 12, wrap after 12 steps
    wr(3'd7, 5'd9);
    do_load(4'd15, 2'b01);
    wraps  = 0;
    wrap_k = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (wrap_pulse) begin
        wraps++;
        wrap_k = k;
      end
      if (k == 113) begin
        chk("clamp_d0_an", 32'(an), 32'hE);
        chk("clamp_d0_seg", 32'(seg), c_S_9);
      end
    end
    chk("clamp_wrap_cnt", 32'(wraps), 32'd1);
    chk("clamp_wrap_at", 32'(wrap_k), 32'd192);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
